tag_dir_assoc: RTL and testbench

- Set-associative tag directory: successor to the single-way tag array, generalised to NUM_WAYS ways.
- Adds per-way valid/dirty state, a one-cycle registered hit/miss lookup, and victim selection (invalid-first, then per-set round-robin).
- Adds a multi-cycle invalidate-all sweep FSM.
- Sits between the cache controller FSM and the data arrays.
- Supplies the hit way for data-array reads, and the victim way, tag and dirty bit for refill/writeback decisions.

---
 rtl/tag_dir_assoc.sv | 217 +++++++++++++++++++++
 tb/tb_tag_dir_assoc.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/tag_dir_assoc.sv
// Set-associative tag directory: registered hit/miss lookup, victim choice
// (invalid-first, then per-set round-robin) and an invalidate-all sweep.
module tag_dir_assoc #(
  parameter int TAG_WIDTH      = 24,
  parameter int SET_ADDR_WIDTH = 3,
  parameter int WAY_IDX_WIDTH  = 2,
  localparam int WW = (WAY_IDX_WIDTH == 0) ? 1 : WAY_IDX_WIDTH
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      lookup_valid,
  output logic                      lookup_ready,
  input  logic [SET_ADDR_WIDTH-1:0] lookup_set,
  input  logic [TAG_WIDTH-1:0]      lookup_tag,
  output logic                      res_valid,
  output logic                      res_hit,
  output logic [WW-1:0]             res_way,
  output logic                      res_dirty,
  output logic [WW-1:0]             victim_way,
  output logic                      victim_valid,
  output logic                      victim_dirty,
  output logic [TAG_WIDTH-1:0]      victim_tag,
  input  logic                      upd_en,
  input  logic [1:0]                upd_op,
  input  logic [SET_ADDR_WIDTH-1:0] upd_set,
  input  logic [WW-1:0]             upd_way,
  input  logic [TAG_WIDTH-1:0]      upd_tag,
  input  logic                      inv_all_req,
  output logic                      busy
);

  localparam int NUM_SETS = 1 << SET_ADDR_WIDTH;
  localparam int NUM_WAYS = 1 << WAY_IDX_WIDTH;

  localparam logic [1:0] OP_FILL  = 2'b00;
  localparam logic [1:0] OP_DIRTY = 2'b01;
  localparam logic [1:0] OP_INV   = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_SWEEP
  } state_e;

  state_e                    state_q, state_d;
  logic [SET_ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic [TAG_WIDTH-1:0] tag_q   [NUM_SETS][NUM_WAYS];
  logic [NUM_WAYS-1:0]  valid_q [NUM_SETS];
  logic [NUM_WAYS-1:0]  dirty_q [NUM_SETS];
  logic [WW-1:0]        rr_q    [NUM_SETS];

  logic                 rv_q;
  logic                 hit_q, hit_d;
  logic [WW-1:0]        hway_q, hway_d;
  logic                 hdirty_q, hdirty_d;
  logic [WW-1:0]        vway_q, vway_d;
  logic                 vvalid_q, vvalid_d;
  logic                 vdirty_q, vdirty_d;
  logic [TAG_WIDTH-1:0] vtag_q, vtag_d;

  logic                accept;
  logic                sweep;
  logic                upd_act;
  logic                inv_found;
  logic [NUM_WAYS-1:0] upd_sel;
  logic [WW-1:0]       rr_fill;

  // FSM
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lookup_ready = 1'b0;
    busy         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        lookup_ready = 1'b1;
        if (inv_all_req) begin
          state_d = S_SWEEP;
          cnt_d   = '0;
        end
      end
      S_SWEEP: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign sweep   = (state_q == S_SWEEP);
  assign accept  = lookup_valid & lookup_ready;
  assign upd_act = upd_en & ~sweep;

  always_comb begin
    upd_sel = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      upd_sel[w] = (WAY_IDX_WIDTH == 0) || (upd_way == WW'(w));
  end

  assign rr_fill = (WAY_IDX_WIDTH == 0) ? '0 : upd_way + WW'(1);

  // Tags carry no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (upd_act && upd_op == OP_FILL) begin
      for (int w = 0; w < NUM_WAYS; w++)
        if (upd_sel[w]) tag_q[upd_set][w] <= upd_tag;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int s = 0; s < NUM_SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        rr_q[s]    <= '0;
      end
    end else if (sweep) begin
      valid_q[cnt_q] <= '0;
      dirty_q[cnt_q] <= '0;
      rr_q[cnt_q]    <= '0;
    end else if (upd_en) begin
      unique case (upd_op)
        OP_FILL: begin
          valid_q[upd_set] <= valid_q[upd_set] | upd_sel;
          dirty_q[upd_set] <= dirty_q[upd_set] & ~upd_sel;
          rr_q[upd_set]    <= rr_fill;
        end
        OP_DIRTY: begin
          dirty_q[upd_set] <= dirty_q[upd_set]
                            | (upd_sel & valid_q[upd_set]);
        end
        OP_INV: begin
          valid_q[upd_set] <= valid_q[upd_set] & ~upd_sel;
          dirty_q[upd_set] <= dirty_q[upd_set] & ~upd_sel;
        end
        default: ;
      endcase
    end
  end

  // Descending scan so the lowest matching / invalid way wins.
  always_comb begin
    hit_d     = 1'b0;
    hway_d    = '0;
    hdirty_d  = 1'b0;
    inv_found = 1'b0;
    vway_d    = rr_q[lookup_set];
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (valid_q[lookup_set][w] &&
          tag_q[lookup_set][w] == lookup_tag) begin
        hit_d    = 1'b1;
        hway_d   = WW'(w);
        hdirty_d = dirty_q[lookup_set][w];
      end
      if (!valid_q[lookup_set][w]) begin
        inv_found = 1'b1;
        vway_d    = WW'(w);
      end
    end
    vvalid_d = ~inv_found;
    vdirty_d = 1'b0;
    vtag_d   = '0;
    if (!inv_found) begin
      for (int w = 0; w < NUM_WAYS; w++) begin
        if (vway_d == WW'(w)) begin
          vdirty_d = dirty_q[lookup_set][w];
          vtag_d   = tag_q[lookup_set][w];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rv_q     <= 1'b0;
      hit_q    <= 1'b0;
      hway_q   <= '0;
      hdirty_q <= 1'b0;
      vway_q   <= '0;
      vvalid_q <= 1'b0;
      vdirty_q <= 1'b0;
      vtag_q   <= '0;
    end else begin
      rv_q <= accept;
      if (accept) begin
        hit_q    <= hit_d;
        hway_q   <= hway_d;
        hdirty_q <= hdirty_d;
        vway_q   <= vway_d;
        vvalid_q <= vvalid_d;
        vdirty_q <= vdirty_d;
        vtag_q   <= vtag_d;
      end
    end
  end

  assign res_valid    = rv_q;
  assign res_hit      = hit_q;
  assign res_way      = hway_q;
  assign res_dirty    = hdirty_q;
  assign victim_way   = vway_q;
  assign victim_valid = vvalid_q;
  assign victim_dirty = vdirty_q;
  assign victim_tag   = vtag_q;

endmodule

// File: tb/tb_tag_dir_assoc.sv
// Scoreboard bench for tag_dir_assoc: directed lookups/updates,
// sweep timing and mid-sweep reset.
module tb_tag_dir_assoc;

  logic        clk = 1'b0;
  logic        resetn;
  logic        lookup_valid;
  logic        lookup_ready;
  logic [2:0]  lookup_set;
  logic [23:0] lookup_tag;
  logic        res_valid;
  logic        res_hit;
  logic [1:0]  res_way;
  logic        res_dirty;
  logic [1:0]  victim_way;
  logic        victim_valid;
  logic        victim_dirty;
  logic [23:0] victim_tag;
  logic        upd_en;
  logic [1:0]  upd_op;
  logic [2:0]  upd_set;
  logic [1:0]  upd_way;
  logic [23:0] upd_tag;
  logic        inv_all_req;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        hit;
    logic [1:0]  way;
    logic        dirty;
    logic [1:0]  vway;
    logic        vvalid;
    logic        vdirty;
    logic [23:0] vtag;
  } exp_t;

  exp_t exp_q[$];

  tag_dir_assoc dut (
    .clk(clk), .resetn(resetn),
    .lookup_valid(lookup_valid), .lookup_ready(lookup_ready),
    .lookup_set(lookup_set), .lookup_tag(lookup_tag),
    .res_valid(res_valid), .res_hit(res_hit),
    .res_way(res_way), .res_dirty(res_dirty),
    .victim_way(victim_way), .victim_valid(victim_valid),
    .victim_dirty(victim_dirty), .victim_tag(victim_tag),
    .upd_en(upd_en), .upd_op(upd_op), .upd_set(upd_set),
    .upd_way(upd_way), .upd_tag(upd_tag),
    .inv_all_req(inv_all_req), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic h, logic [1:0] w, logic d,
                              logic [1:0] vw, logic vv, logic vd,
                              logic [23:0] vt);
    exp_t e;
    e.hit = h; e.way = w; e.dirty = d;
    e.vway = vw; e.vvalid = vv; e.vdirty = vd; e.vtag = vt;
    return e;
  endfunction

  // Monitor: pops one expectation per res_valid pulse.
  always @(negedge clk) begin
    if (resetn && res_valid) begin
      exp_t a, e;
      a = {res_hit, res_way, res_dirty, victim_way,
           victim_valid, victim_dirty, victim_tag};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_res_valid got %h", a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL lookup got h=%b w=%0d d=%b vw=%0d vv=%b vd=%b vt=%h exp h=%b w=%0d d=%b vw=%0d vv=%b vd=%b vt=%h",
                   a.hit, a.way, a.dirty, a.vway, a.vvalid, a.vdirty, a.vtag,
                   e.hit, e.way, e.dirty, e.vway, e.vvalid, e.vdirty, e.vtag);
        end
      end
    end
  end

  task automatic chk(string nm, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h exp %h", nm, got, want);
    end
  endtask

  task automatic clr();
    lookup_valid = 0; lookup_set = 0; lookup_tag = 0;
    upd_en = 0; upd_op = 2'b11; upd_set = 0; upd_way = 0;
    upd_tag = 0; inv_all_req = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic lk(logic [2:0] s, logic [23:0] t, exp_t e);
    lookup_valid = 1; lookup_set = s; lookup_tag = t;
    exp_q.push_back(e);
  endtask

  task automatic up(logic [1:0] op, logic [2:0] s, logic [1:0] w,
                    logic [23:0] t);
    upd_en = 1; upd_op = op; upd_set = s; upd_way = w; upd_tag = t;
  endtask

  initial begin
    int n;
    bit rdy_bad;
    clr();
    resetn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 32'(lookup_ready), 1);
    chk("rst_res_valid", 32'(res_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_outs", {res_hit, res_way, res_dirty, victim_way,
                     victim_valid, victim_dirty}, 0);
    chk("rst_vtag", 32'(victim_tag), 0);
    resetn = 1;
    step();

    lk(3, 24'hABCDEF, mk(0, 0, 0, 0, 0, 0, 0)); step();
    up(2'b00, 3, 0, 24'hABCDEF); step();
    lk(3, 24'hABCDEF, mk(1, 0, 0, 1, 0, 0, 0)); step();
    up(2'b01, 3, 0, 0); step();
    lk(3, 24'hABCDEF, mk(1, 0, 1, 1, 0, 0, 0)); step();

    for (int w = 0; w < 4; w++) begin
      up(2'b00, 5, 2'(w), 24'h10 + 24'(w)); step();
    end
    lk(5, 24'h99, mk(0, 0, 0, 0, 1, 0, 24'h10)); step();
    up(2'b00, 5, 0, 24'h20); step();
    lk(5, 24'h99, mk(0, 0, 0, 1, 1, 0, 24'h11)); step();
    lk(5, 24'h12, mk(1, 2, 0, 1, 1, 0, 24'h11)); step();
    up(2'b01, 5, 1, 0); step();
    lk(5, 24'h99, mk(0, 0, 0, 1, 1, 1, 24'h11)); step();
    lk(5, 24'h11, mk(1, 1, 1, 1, 1, 1, 24'h11)); step();
    up(2'b10, 5, 2, 0); step();
    lk(5, 24'h12, mk(0, 0, 0, 2, 0, 0, 0)); step();
    up(2'b01, 5, 2, 0); step();
    lk(5, 24'h12, mk(0, 0, 0, 2, 0, 0, 0)); step();

    up(2'b00, 2, 0, 24'h55);
    lk(2, 24'h55, mk(0, 0, 0, 0, 0, 0, 0)); step();
    lk(2, 24'h55, mk(1, 0, 0, 1, 0, 0, 0)); step();

    lk(3, 24'hABCDEF, mk(1, 0, 1, 1, 0, 0, 0));
    inv_all_req = 1;
    step();
    n = 0;
    rdy_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (!busy) break;
      if (lookup_ready) rdy_bad = 1;
      n++;
      step();
    end
    chk("sweep_cycles", 32'(n), 8);
    chk("sweep_ready_low", 32'(rdy_bad), 0);
    chk("post_sweep_ready", 32'(lookup_ready), 1);
    lk(3, 24'hABCDEF, mk(0, 0, 0, 0, 0, 0, 0)); step();
    lk(5, 24'h20, mk(0, 0, 0, 0, 0, 0, 0)); step();
    lk(2, 24'h55, mk(0, 0, 0, 0, 0, 0, 0)); step();

    up(2'b00, 1, 0, 24'h77); step();
    inv_all_req = 1; step();
    repeat (3) step();
    chk("sweep_mid_busy", 32'(busy), 1);
    #2;
    resetn = 0;
    #1;
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_ready", 32'(lookup_ready), 1);
    chk("rst_mid_res_valid", 32'(res_valid), 0);
    @(posedge clk);
    #1;
    resetn = 1;
    repeat (3) step();
    chk("after_rst_busy", 32'(busy), 0);
    lk(1, 24'h77, mk(0, 0, 0, 0, 0, 0, 0)); step();
    lk(5, 24'h11, mk(0, 0, 0, 0, 0, 0, 0)); step();
    repeat (3) step();
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
